// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous 32-bit SRAM.
// Port 0 is a read-only fetch port; port 1 reads or writes with byte enables.
module sram_arbiter #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        clk_50M,
    input  logic        reset_btn,
    input  logic        m0_req,
    input  logic [19:0] m0_addr,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [19:0] m1_addr,
    input  logic [3:0]  m1_be_n,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [31:0] ram_data_o,
    output logic        ram_data_oe,
    input  logic [31:0] ram_data_i
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE} state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        gnt1, wr, prio1;   // prio1: port 1 wins the next tie
    logic [19:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        start, pick1;
    logic        ce_d, oe_d, we_d, doe_d, ack0_d, ack1_d, busy_d;
    logic [3:0]  be_d;

    assign start = m0_req | m1_req;
    assign pick1 = m1_req & (~m0_req | prio1);

    always_ff @(posedge clk_50M) begin
        if (reset_btn) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start) state_nx = (pick1 && m1_we) ? S_WR_SETUP : S_RD;
            S_RD:       if (cnt == RD_LAST) state_nx = S_DONE;
            S_WR_SETUP: state_nx = S_WR_PULSE;
            S_WR_PULSE: if (cnt == WR_LAST) state_nx = S_WR_HOLD;
            S_WR_HOLD:  state_nx = S_DONE;
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ce_d   = 1'b1;
        oe_d   = 1'b1;
        we_d   = 1'b1;
        be_d   = 4'hF;
        doe_d  = 1'b0;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        busy_d = (state != S_IDLE);
        case (state)
            S_RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                be_d = 4'h0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                ce_d  = 1'b0;
                be_d  = be_q;
                doe_d = 1'b1;
            end
            S_WR_PULSE: begin
                ce_d  = 1'b0;
                we_d  = 1'b0;
                be_d  = be_q;
                doe_d = 1'b1;
            end
            S_DONE: begin
                ack0_d = ~gnt1;
                ack1_d = gnt1;
            end
            default: ;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk_50M) begin
        if (reset_btn || state_nx != state) cnt <= '0;
        else                                cnt <= cnt + 4'd1;
    end

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            prio1   <= 1'b1;
            gnt1    <= 1'b0;
            wr      <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'hF;
            wdata_q <= '0;
        end else if (state == S_IDLE && start) begin
            prio1   <= ~pick1;
            gnt1    <= pick1;
            wr      <= pick1 & m1_we;
            addr_q  <= pick1 ? m1_addr : m0_addr;
            be_q    <= m1_be_n;
            wdata_q <= m1_wdata;
        end
    end

    // Pins trail the state by one register, so the last cycle with oe_n low
    // on the pins is the cycle the FSM sits in DONE: capture there.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= 4'hF;
            ram_data_oe <= 1'b0;
            ram_addr    <= '0;
            ram_data_o  <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            busy        <= 1'b0;
            rdata       <= '0;
        end else begin
            ram_ce_n    <= ce_d;
            ram_oe_n    <= oe_d;
            ram_we_n    <= we_d;
            ram_be_n    <= be_d;
            ram_data_oe <= doe_d;
            ram_addr    <= addr_q;
            ram_data_o  <= wdata_q;
            m0_ack      <= ack0_d;
            m1_ack      <= ack1_d;
            busy        <= busy_d;
            if (state == S_DONE && !wr) rdata <= ram_data_i;
        end
    end
endmodule
